dds_sweep_ctrl: RTL and testbench

// - Frequency-sweep sequencer for the DDS core: drives the phase-accumulator tuning word

---
 rtl/dds_pkg.sv | 30 +++
 rtl/dds_sweep_ctrl_if.sv | 27 ++
 rtl/dds_sweep_regs.sv | 76 +++++++
 rtl/dds_sweep_ctrl.sv | 161 ++++++++++++++++
 tb/tb_dds_sweep_ctrl.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dds_pkg.sv
// dds_pkg: shared constants for the DDS frequency-sweep controller.
//  - register map addresses for the byte-wide write port
//  - CTRL register bit positions
//  - sweep FSM state encoding
// Optional feature macro: DDS_SWEEP_BIDIR_EN (adds the DN state and the CTRL.bidir bit).
package dds_pkg;

  localparam logic [2:0] ADDR_START_L = 3'd0;
  localparam logic [2:0] ADDR_START_H = 3'd1;
  localparam logic [2:0] ADDR_STOP_L  = 3'd2;
  localparam logic [2:0] ADDR_STOP_H  = 3'd3;
  localparam logic [2:0] ADDR_STEP_L  = 3'd4;
  localparam logic [2:0] ADDR_STEP_H  = 3'd5;
  localparam logic [2:0] ADDR_DWELL   = 3'd6;
  localparam logic [2:0] ADDR_CTRL    = 3'd7;

  localparam int CTRL_RUN     = 0;
  localparam int CTRL_ONESHOT = 1;
  localparam int CTRL_BIDIR   = 2;

`ifdef DDS_SWEEP_BIDIR_EN
  localparam int CTRL_W = 3;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_UP = 2'd1, ST_DN = 2'd2} state_t;
`else
  // Without the triangular mode the bidir bit is simply not stored.
  localparam int CTRL_W = 2;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_UP = 2'd1} state_t;
`endif

endpackage

// File: rtl/dds_sweep_ctrl_if.sv
// dds_sweep_ctrl_if: pin-side bundle of the sweep controller.
//  master (register host / DDS consumer): drives ena, wr_en, wr_addr, wr_data;
//         receives tune_word, tune_valid, phase_rst, busy, done.
//  slave  (dds_sweep_ctrl): the mirror image.
interface dds_sweep_ctrl_if #(
  parameter int TUNE_W = 16
);
  logic              ena;
  logic              wr_en;
  logic [2:0]        wr_addr;
  logic [7:0]        wr_data;
  logic [TUNE_W-1:0] tune_word;
  logic              tune_valid;
  logic              phase_rst;
  logic              busy;
  logic              done;

  modport master (
    output ena, wr_en, wr_addr, wr_data,
    input  tune_word, tune_valid, phase_rst, busy, done
  );

  modport slave (
    input  ena, wr_en, wr_addr, wr_data,
    output tune_word, tune_valid, phase_rst, busy, done
  );
endinterface

// File: rtl/dds_sweep_regs.sv
// dds_sweep_regs: byte-wide register file plus per-pass shadow copies.
//  clk, rst          clock, async active-high reset
//  wr_en/addr/data   register write port (one byte per cycle)
//  latch             copy live registers into shadows (pass start)
//  run_clr           clear CTRL.run (one-shot completion); a same-cycle CTRL write wins
//  start_r, dwell_r  live START / DWELL (used to load the first word of a pass)
//  ctrl              live CTRL bits
//  stop_req          this cycle carries a CTRL write with run=0
//  *_s               shadow START/STOP/STEP/DWELL used during the pass
// Macro DDS_SWEEP_BIDIR_EN widens CTRL to hold the bidir bit.
module dds_sweep_regs
  import dds_pkg::*;
#(
  parameter int TUNE_W  = 16,
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [2:0]         wr_addr,
  input  logic [7:0]         wr_data,
  input  logic               latch,
  input  logic               run_clr,
  output logic [TUNE_W-1:0]  start_r,
  output logic [DWELL_W-1:0] dwell_r,
  output logic [CTRL_W-1:0]  ctrl,
  output logic               stop_req,
  output logic [TUNE_W-1:0]  start_s,
  output logic [TUNE_W-1:0]  stop_s,
  output logic [TUNE_W-1:0]  step_s,
  output logic [DWELL_W-1:0] dwell_s
);

  logic [TUNE_W-1:0] stop_r, step_r;
  logic              ctrl_wr;

  assign ctrl_wr  = wr_en && (wr_addr == ADDR_CTRL);
  assign stop_req = ctrl_wr && !wr_data[CTRL_RUN];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_r <= '0;
      stop_r  <= '0;
      step_r  <= '0;
      dwell_r <= '0;
      ctrl    <= '0;
      start_s <= '0;
      stop_s  <= '0;
      step_s  <= '0;
      dwell_s <= '0;
    end else begin
      // High bytes only keep the bits that fit in TUNE_W.
      if (wr_en) begin
        case (wr_addr)
          ADDR_START_L: start_r[7:0]        <= wr_data;
          ADDR_START_H: start_r[TUNE_W-1:8] <= wr_data[TUNE_W-9:0];
          ADDR_STOP_L:  stop_r[7:0]         <= wr_data;
          ADDR_STOP_H:  stop_r[TUNE_W-1:8]  <= wr_data[TUNE_W-9:0];
          ADDR_STEP_L:  step_r[7:0]         <= wr_data;
          ADDR_STEP_H:  step_r[TUNE_W-1:8]  <= wr_data[TUNE_W-9:0];
          ADDR_DWELL:   dwell_r             <= DWELL_W'(wr_data);
          ADDR_CTRL:    ctrl                <= wr_data[CTRL_W-1:0];
          default: ;
        endcase
      end
      if (run_clr && !ctrl_wr) ctrl[CTRL_RUN] <= 1'b0;
      if (latch) begin
        start_s <= start_r;
        stop_s  <= stop_r;
        step_s  <= step_r;
        dwell_s <= dwell_r;
      end
    end
  end

endmodule

// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: frequency-sweep sequencer feeding the DDS phase accumulator.
//  clk, rst  clock, async active-high reset
//  bus       dds_sweep_ctrl_if.slave: ena, register write port in;
//            tune_word, tune_valid, phase_rst, busy, done out
// Ramps tune_word start->stop in step increments, each word held dwell+1 enabled
// cycles; one-shot or repeating. Default repeat is sawtooth. With macro
// DDS_SWEEP_BIDIR_EN, CTRL.bidir turns repeat into a triangle via the DN state.
module dds_sweep_ctrl
  import dds_pkg::*;
#(
  parameter int TUNE_W  = 16,
  parameter int DWELL_W = 8
) (
  input logic             clk,
  input logic             rst,
  dds_sweep_ctrl_if.slave bus
);

  logic [TUNE_W-1:0]  start_r, start_s, stop_s, step_s;
  logic [DWELL_W-1:0] dwell_r, dwell_s;
  logic [CTRL_W-1:0]  ctrl;
  logic               stop_req, latch, run_clr;

  state_t             state;
  logic [DWELL_W-1:0] cnt;
  logic [TUNE_W-1:0]  tw;
  logic               tv, pr, dn;

  logic               run, oneshot, bidir;
  logic               go, abort, step_evt, up_end, dn_end, at_stop;
  logic [TUNE_W:0]    up_sum;
  logic [TUNE_W-1:0]  up_next;

  dds_sweep_regs #(.TUNE_W(TUNE_W), .DWELL_W(DWELL_W)) u_regs (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (bus.wr_en),
    .wr_addr  (bus.wr_addr),
    .wr_data  (bus.wr_data),
    .latch    (latch),
    .run_clr  (run_clr),
    .start_r  (start_r),
    .dwell_r  (dwell_r),
    .ctrl     (ctrl),
    .stop_req (stop_req),
    .start_s  (start_s),
    .stop_s   (stop_s),
    .step_s   (step_s),
    .dwell_s  (dwell_s)
  );

  assign run     = ctrl[CTRL_RUN];
  assign oneshot = ctrl[CTRL_ONESHOT];

  // Up step: one extra bit so a large step saturates at stop instead of wrapping.
  assign up_sum  = {1'b0, tw} + {1'b0, step_s};
  assign up_next = (up_sum >= {1'b0, stop_s}) ? stop_s : up_sum[TUNE_W-1:0];
  assign at_stop = (tw >= stop_s);  // also covers start >= stop

`ifdef DDS_SWEEP_BIDIR_EN
  logic [TUNE_W:0]   dn_diff;
  logic [TUNE_W-1:0] dn_next;
  logic              at_start;

  assign bidir    = ctrl[CTRL_BIDIR];
  // Borrow out of the top bit means we went below zero: clamp to start.
  assign dn_diff  = {1'b0, tw} - {1'b0, step_s};
  assign dn_next  = (dn_diff[TUNE_W] || (dn_diff[TUNE_W-1:0] <= start_s)) ? start_s
                                                                           : dn_diff[TUNE_W-1:0];
  assign at_start = (dn_next == start_s);
  assign dn_end   = step_evt && (state == ST_DN) && at_start;
`else
  assign bidir    = 1'b0;
  assign dn_end   = 1'b0;
`endif

  // Aborting has priority over a step, so a run=0 write on the last step suppresses done.
  assign go       = bus.ena && (state == ST_IDLE) && run && !stop_req;
  assign abort    = bus.ena && (state != ST_IDLE) && (stop_req || !run);
  assign step_evt = bus.ena && (state != ST_IDLE) && !abort && (cnt == '0) && (step_s != '0);
  assign up_end   = step_evt && (state == ST_UP) && at_stop;

  // Shadows refresh whenever a new up-pass begins.
  assign latch    = go || (up_end && !oneshot && !bidir) || (dn_end && !oneshot);
  assign run_clr  = (up_end || dn_end) && oneshot;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      tw    <= '0;
      tv    <= 1'b0;
      pr    <= 1'b0;
      dn    <= 1'b0;
    end else begin
      tv <= 1'b0;
      pr <= 1'b0;
      dn <= 1'b0;
      if (go) begin
        tw    <= start_r;
        tv    <= 1'b1;
        pr    <= 1'b1;
        cnt   <= dwell_r;
        state <= ST_UP;
      end else if (abort) begin
        state <= ST_IDLE;
      end else if (bus.ena && (state != ST_IDLE) && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end else if (step_evt) begin
        cnt <= dwell_s;
        if (state == ST_UP) begin
          if (!at_stop) begin
            tw <= up_next;
            tv <= 1'b1;
          end else if (oneshot) begin
            dn    <= 1'b1;
            state <= ST_IDLE;
`ifdef DDS_SWEEP_BIDIR_EN
          end else if (bidir) begin
            // Turn around immediately so stop is held only one dwell.
            tw    <= dn_next;
            tv    <= 1'b1;
            state <= ST_DN;
`endif
          end else begin
            // Sawtooth wrap: restart from the freshly latched START.
            tw  <= start_r;
            tv  <= 1'b1;
            pr  <= 1'b1;
            dn  <= 1'b1;
            cnt <= dwell_r;
          end
        end
`ifdef DDS_SWEEP_BIDIR_EN
        else begin
          tw <= dn_next;
          tv <= 1'b1;
          if (at_start) begin
            dn <= 1'b1;
            if (oneshot) begin
              state <= ST_IDLE;
            end else begin
              tw    <= start_r;
              pr    <= 1'b1;
              cnt   <= dwell_r;
              state <= ST_UP;
            end
          end
        end
`endif
      end
    end
  end

  assign bus.tune_word  = tw;
  assign bus.tune_valid = tv;
  assign bus.phase_rst  = pr;
  assign bus.done       = dn;
  assign bus.busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Testbench for dds_sweep_ctrl: directed and randomized sweeps checked cycle by
// cycle against an expected trace built from the ramp rules (word lists, holds).
module tb_dds_sweep_ctrl;
  import dds_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dds_sweep_ctrl_if #(.TUNE_W(16)) bus ();
  dds_sweep_ctrl #(.TUNE_W(16), .DWELL_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [15:0] w;
    logic        tv;
    logic        pr;
    logic        dn;
    logic        bz;
  } obs_t;

  obs_t        exp_q[$];
  logic [15:0] up_q[$];
  logic [15:0] dn_q[$];
  int          n_chk = 0;
  int          n_ok  = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic cfg(input logic [15:0] st, input logic [15:0] sp,
                     input logic [15:0] stp, input logic [7:0] dw);
    wr(ADDR_START_L, st[7:0]);  wr(ADDR_START_H, st[15:8]);
    wr(ADDR_STOP_L,  sp[7:0]);  wr(ADDR_STOP_H,  sp[15:8]);
    wr(ADDR_STEP_L,  stp[7:0]); wr(ADDR_STEP_H,  stp[15:8]);
    wr(ADDR_DWELL,   dw);
  endtask

  // Word lists of one ramp: up from start to stop, down from stop back to start.
  function automatic void make_lists(input logic [15:0] st, input logic [15:0] sp,
                                     input logic [15:0] stp);
    int w;
    up_q.delete(); dn_q.delete();
    w = int'(st);
    up_q.push_back(16'(w));
    while (w < int'(sp)) begin
      w = (w + int'(stp) >= int'(sp)) ? int'(sp) : w + int'(stp);
      up_q.push_back(16'(w));
    end
    w = int'(sp);
    while (w > int'(st)) begin
      w = (w - int'(stp) <= int'(st)) ? int'(st) : w - int'(stp);
      dn_q.push_back(16'(w));
    end
  endfunction

  function automatic void push_hold(input logic [15:0] w, input logic pr, input logic dn,
                                    input int dw);
    obs_t o;
    for (int r = 0; r <= dw; r++) begin
      o.w = w; o.tv = (r == 0); o.pr = (r == 0) && pr; o.dn = (r == 0) && dn; o.bz = 1'b1;
      exp_q.push_back(o);
    end
  endfunction

  function automatic void push_idle(input logic [15:0] w, input logic dn);
    obs_t o;
    o.w = w; o.tv = 1'b0; o.pr = 1'b0; o.dn = dn; o.bz = 1'b0;
    exp_q.push_back(o);
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_chk++; if (bus.tune_word !== 16'h0) $display("FAIL reset_word got %h want 0000", bus.tune_word); else n_ok++;
    n_chk++; if (bus.tune_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", bus.tune_valid); else n_ok++;
    n_chk++; if (bus.phase_rst !== 1'b0) $display("FAIL reset_phase_rst got %b want 0", bus.phase_rst); else n_ok++;
    n_chk++; if (bus.done !== 1'b0) $display("FAIL reset_done got %b want 0", bus.done); else n_ok++;
    n_chk++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else n_ok++;
    rst = 1'b0;
    tick(); tick();
    n_chk++; if ({bus.tune_word, bus.busy} !== 17'h0) $display("FAIL post_reset_idle got w=%h busy=%b want 0000/0", bus.tune_word, bus.busy); else n_ok++;
  endtask

  // One-shot pass; a STOP write lands mid-pass and must not affect it.
  task automatic test_oneshot(input logic [15:0] st, input logic [15:0] sp,
                              input logic [15:0] stp, input logic [7:0] dw);
    logic [15:0] last;
    cfg(st, sp, stp, dw);
    make_lists(st, sp, stp);
    exp_q.delete();
    foreach (up_q[i]) push_hold(up_q[i], i == 0, 1'b0, int'(dw));
    last = up_q[up_q.size()-1];
    push_idle(last, 1'b1);
    for (int i = 0; i < 3; i++) push_idle(last, 1'b0);  // run cleared: no restart
    wr(ADDR_CTRL, 8'b0000_0011);
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k == 1) begin
        bus.wr_en = 1'b1; bus.wr_addr = ADDR_STOP_L; bus.wr_data = 8'($urandom);
      end else begin
        bus.wr_en = 1'b0;
      end
      tick();
      n_chk++;
      if ({bus.tune_word, bus.tune_valid, bus.phase_rst, bus.done, bus.busy} !== exp_q[k])
        $display("FAIL oneshot st=%h sp=%h stp=%h dw=%0d k=%0d got w=%h tv=%b pr=%b dn=%b bz=%b want w=%h tv=%b pr=%b dn=%b bz=%b",
                 st, sp, stp, dw, k, bus.tune_word, bus.tune_valid, bus.phase_rst, bus.done, bus.busy,
                 exp_q[k].w, exp_q[k].tv, exp_q[k].pr, exp_q[k].dn, exp_q[k].bz);
      else n_ok++;
    end
  endtask

  // Repeating sweep for ncyc cycles, then a run=0 write aborts it.
  task automatic test_repeat(input logic [15:0] st, input logic [15:0] sp,
                             input logic [15:0] stp, input logic [7:0] dw,
                             input logic bidir, input int ncyc);
    logic tri_mode;
    logic [15:0] held;
`ifdef DDS_SWEEP_BIDIR_EN
    tri_mode = bidir;
`else
    tri_mode = 1'b0;
`endif
    cfg(st, sp, stp, dw);
    make_lists(st, sp, stp);
    exp_q.delete();
    for (int p = 0; exp_q.size() < ncyc; p++) begin
      if (p > 0 && tri_mode) begin
        foreach (dn_q[j]) push_hold(dn_q[j], j == dn_q.size()-1, j == dn_q.size()-1, int'(dw));
        for (int i = 1; i < up_q.size(); i++) push_hold(up_q[i], 1'b0, 1'b0, int'(dw));
      end else begin
        foreach (up_q[i]) push_hold(up_q[i], i == 0, (i == 0) && (p > 0), int'(dw));
      end
    end
    wr(ADDR_CTRL, {5'b0, bidir, 2'b01});
    for (int k = 0; k < ncyc; k++) begin
      tick();
      n_chk++;
      if ({bus.tune_word, bus.tune_valid, bus.phase_rst, bus.done, bus.busy} !== exp_q[k])
        $display("FAIL repeat bidir=%b st=%h sp=%h stp=%h dw=%0d k=%0d got w=%h tv=%b pr=%b dn=%b bz=%b want w=%h tv=%b pr=%b dn=%b bz=%b",
                 bidir, st, sp, stp, dw, k, bus.tune_word, bus.tune_valid, bus.phase_rst, bus.done, bus.busy,
                 exp_q[k].w, exp_q[k].tv, exp_q[k].pr, exp_q[k].dn, exp_q[k].bz);
      else n_ok++;
    end
    held = exp_q[ncyc-1].w;
    wr(ADDR_CTRL, 8'h00);
    n_chk++; if (bus.busy !== 1'b0) $display("FAIL abort_busy got %b want 0", bus.busy); else n_ok++;
    n_chk++; if (bus.tune_word !== held) $display("FAIL abort_word got %h want %h", bus.tune_word, held); else n_ok++;
    n_chk++; if ({bus.done, bus.tune_valid, bus.phase_rst} !== 3'b000) $display("FAIL abort_pulses got %b want 000", {bus.done, bus.tune_valid, bus.phase_rst}); else n_ok++;
    tick();
    n_chk++; if ({bus.tune_word, bus.busy, bus.done} !== {held, 2'b00}) $display("FAIL abort_stay got w=%h busy=%b done=%b want %h/0/0", bus.tune_word, bus.busy, bus.done, held); else n_ok++;
  endtask

  // Saturating big step plus a 10-cycle ena gap inside the first dwell.
  task automatic test_ena();
    obs_t o;
    cfg(16'hFF00, 16'hFFF0, 16'hFFFF, 8'd5);
    exp_q.delete();
    push_hold(16'hFF00, 1'b1, 1'b0, 5 + 10);
    push_hold(16'hFFF0, 1'b0, 1'b0, 5);
    push_idle(16'hFFF0, 1'b1);
    push_idle(16'hFFF0, 1'b0);
    wr(ADDR_CTRL, 8'b0000_0011);
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k == 3)  bus.ena = 1'b0;
      if (k == 13) bus.ena = 1'b1;
      tick();
      o = exp_q[k];
      n_chk++;
      if ({bus.tune_word, bus.tune_valid, bus.phase_rst, bus.done, bus.busy} !== o)
        $display("FAIL ena_hold k=%0d got w=%h tv=%b pr=%b dn=%b bz=%b want w=%h tv=%b pr=%b dn=%b bz=%b",
                 k, bus.tune_word, bus.tune_valid, bus.phase_rst, bus.done, bus.busy, o.w, o.tv, o.pr, o.dn, o.bz);
      else n_ok++;
    end
  endtask

  // Async reset mid-sweep, then a run with all-zero registers: STEP=0 holds forever.
  task automatic test_reset_mid();
    cfg(16'h1234, 16'h2000, 16'h0001, 8'd2);
    wr(ADDR_CTRL, 8'b0000_0011);
    for (int i = 0; i < 5; i++) tick();
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if ({bus.tune_word, bus.tune_valid, bus.phase_rst, bus.done, bus.busy} !== 20'h0)
      $display("FAIL async_reset got w=%h tv=%b pr=%b dn=%b bz=%b want all 0",
               bus.tune_word, bus.tune_valid, bus.phase_rst, bus.done, bus.busy);
    else n_ok++;
    tick();
    rst = 1'b0;
    exp_q.delete();
    push_hold(16'h0000, 1'b1, 1'b0, 0);
    for (int i = 0; i < 19; i++) push_hold(16'h0000, 1'b0, 1'b0, -1);
    for (int i = 0; i < 19; i++) exp_q.push_back(obs_t'({16'h0000, 1'b0, 1'b0, 1'b0, 1'b1}));
    wr(ADDR_CTRL, 8'b0000_0011);
    for (int k = 0; k < exp_q.size(); k++) begin
      tick();
      n_chk++;
      if ({bus.tune_word, bus.tune_valid, bus.phase_rst, bus.done, bus.busy} !== exp_q[k])
        $display("FAIL step_zero k=%0d got w=%h tv=%b pr=%b dn=%b bz=%b want w=%h tv=%b pr=%b dn=%b bz=%b",
                 k, bus.tune_word, bus.tune_valid, bus.phase_rst, bus.done, bus.busy,
                 exp_q[k].w, exp_q[k].tv, exp_q[k].pr, exp_q[k].dn, exp_q[k].bz);
      else n_ok++;
    end
    wr(ADDR_CTRL, 8'h00);
    n_chk++; if ({bus.busy, bus.done} !== 2'b00) $display("FAIL step_zero_abort got busy=%b done=%b want 0/0", bus.busy, bus.done); else n_ok++;
  endtask

  task automatic test_random();
    logic [15:0] st, sp, stp;
    logic [7:0]  dw;
    for (int n = 0; n < 6; n++) begin
      st = 16'($urandom);
      if ($urandom_range(0, 3) == 0) sp = 16'($urandom_range(0, int'(st)));
      else sp = 16'((int'(st) + int'($urandom_range(0, 40)) > 65535) ? 65535
                                                                    : int'(st) + int'($urandom_range(0, 40)));
      stp = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(1, 8)) : 16'($urandom_range(1, 65535));
      dw  = 8'($urandom_range(0, 3));
      test_oneshot(st, sp, stp, dw);
    end
    for (int n = 0; n < 2; n++) begin
      st  = 16'($urandom_range(0, 1000));
      sp  = st + 16'($urandom_range(1, 20));
      stp = 16'($urandom_range(1, 6));
      dw  = 8'($urandom_range(0, 2));
      test_repeat(st, sp, stp, dw, 1'($urandom_range(0, 1)), 60);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.ena = 1'b1; bus.wr_en = 1'b0; bus.wr_addr = 3'd0; bus.wr_data = 8'd0;
    test_reset();
    test_oneshot(16'h0100, 16'h0104, 16'h0001, 8'd0);
    test_oneshot(16'h0100, 16'h0105, 16'h0002, 8'd3);
    test_oneshot(16'h0200, 16'h0180, 16'h0004, 8'd1);
    test_repeat(16'h0000, 16'h0002, 16'h0001, 8'd0, 1'b0, 12);
    test_repeat(16'h0000, 16'h0002, 16'h0001, 8'd0, 1'b1, 14);
    test_repeat(16'h0000, 16'h0005, 16'h0002, 8'd1, 1'b1, 40);
    test_ena();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end

endmodule
